// File: rtl/dff_arb_pkg.sv
// Shared types, default sizes and the round-robin search helper for the
// dff_bank_arbiter block.
package dff_arb_pkg;

   typedef enum logic {IDLE, GRANT} state_t;

   localparam int DEF_N_REQ    = 4;
   localparam int DEF_WIDTH    = 8;
   localparam int DEF_MAX_HOLD = 4;

   // Index of the first requester set in req, searching upward from ptr+1
   // and wrapping modulo n (n <= 8). If only ptr itself requests, ptr wins.
   // With no request at all, ptr is returned unchanged.
   function automatic logic [2:0] rr_next(input logic [7:0] req,
                                          input logic [2:0] ptr,
                                          input int         n);
      logic [2:0] idx;
      logic [2:0] win;
      logic       found;
      win   = ptr;
      found = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         idx = 3'((int'(ptr) + i) % n);
         if ((i <= n) && !found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/dff_reg.sv
// WIDTH-bit D register with load enable; clears asynchronously to zero.
module dff_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Bank storage: load d whenever the arbiter enables a write.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter owning a single shared WIDTH-bit register bank.
// One requester is granted at a time; a granted, still-requesting
// requester writes its data at the edge and the grant then rotates.
// Optional feature: define DFF_ARB_LOCK_EN to let a grantee keep the bank
// for up to MAX_HOLD consecutive writes before the grant rotates.
module dff_bank_arbiter
   import dff_arb_pkg::*;
#(
   parameter int N_REQ    = DEF_N_REQ,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic                     clk_i,
   input  logic                     resetn_i,
   input  logic [N_REQ-1:0]         req_i,
   input  logic [N_REQ*WIDTH-1:0]   data_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic [WIDTH-1:0]         q_o,
   output logic [$clog2(N_REQ)-1:0] owner_o,
   output logic                     upd_o
);

   localparam int IDX_W = $clog2(N_REQ);

   state_t           state;
   logic [IDX_W-1:0] rr_ptr;   // last grantee; equals the current grantee in GRANT
   logic [IDX_W-1:0] win;
   logic [7:0]       req_pad;
   logic             any_req;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             keep;     // stay on the current grantee this edge

   assign req_pad = 8'(req_i);
   assign any_req = |req_i;
   assign win     = IDX_W'(rr_next(req_pad, 3'(rr_ptr), N_REQ));
   assign wr_en   = (state == GRANT) && req_i[rr_ptr];
   assign wr_data = data_i[int'(rr_ptr)*WIDTH +: WIDTH];

`ifdef DFF_ARB_LOCK_EN
   localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   logic [HOLD_W-1:0] hold_cnt;

   assign keep = wr_en && (int'(hold_cnt) < MAX_HOLD - 1);

   // Consecutive-write counter: counts kept writes, clears on any rotation.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         hold_cnt <= '0;
      end else if (keep) begin
         hold_cnt <= hold_cnt + HOLD_W'(1);
      end else begin
         hold_cnt <= '0;
      end
   end
`else
   assign keep = 1'b0;
`endif

   // Arbitration FSM with registered grant, owner and update pulse.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state   <= IDLE;
         gnt_o   <= '0;
         rr_ptr  <= IDX_W'(N_REQ - 1);
         owner_o <= '0;
         upd_o   <= 1'b0;
      end else begin
         upd_o <= wr_en;
         if (wr_en) begin
            owner_o <= rr_ptr;
         end
         case (state)
            IDLE: begin
               if (any_req) begin
                  state  <= GRANT;
                  gnt_o  <= N_REQ'(1) << win;
                  rr_ptr <= win;
               end
            end
            GRANT: begin
               if (keep) begin
                  state <= GRANT;
               end else if (!any_req) begin
                  state <= IDLE;
                  gnt_o <= '0;
               end else begin
                  gnt_o  <= N_REQ'(1) << win;
                  rr_ptr <= win;
               end
            end
            default: begin
               state <= IDLE;
               gnt_o <= '0;
            end
         endcase
      end
   end

   dff_reg #(
      .WIDTH (WIDTH)
   ) u_bank (
      .clk    (clk_i),
      .resetn (resetn_i),
      .en     (wr_en),
      .d      (wr_data),
      .q      (q_o)
   );

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter (N_REQ=4, WIDTH=8, MAX_HOLD=4).
// Expected sequences follow DFF_ARB_LOCK_EN when it is defined.
module tb_dff_bank_arbiter;

   logic        clk;
   logic        resetn;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  gnt;
   logic [7:0]  q;
   logic [1:0]  owner;
   logic        upd;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef DFF_ARB_LOCK_EN
   int exp_cq[5]   = '{'h10, 'h10, 'h10, 'h10, 'h11};
   int exp_cown[5] = '{0, 0, 0, 0, 1};
   localparam int LOCK_N = 9;
   int exp_lown[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`else
   int exp_cq[5]   = '{'h10, 'h11, 'h12, 'h13, 'h10};
   int exp_cown[5] = '{0, 1, 2, 3, 0};
   localparam int LOCK_N = 4;
   int exp_lown[4] = '{0, 1, 0, 1};
`endif

   dff_bank_arbiter #(
      .N_REQ    (4),
      .WIDTH    (8),
      .MAX_HOLD (4)
   ) dut (
      .clk_i    (clk),
      .resetn_i (resetn),
      .req_i    (req),
      .data_i   (data),
      .gnt_o    (gnt),
      .q_o      (q),
      .owner_o  (owner),
      .upd_o    (upd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int k, input logic [7:0] v);
      data[k*8 +: 8] = v;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      req    = 4'h0;
      #3;
      resetn = 1'b1;
   endtask

   initial begin
      clk    = 1'b0;
      resetn = 1'b0;
      req    = 4'hF;
      data   = '0;
      for (int k = 0; k < 4; k++) set_data(k, 8'(8'h10 + k));

      // Reset held with all requesters active
      #12;
      check("rst_gnt", gnt, 0);
      check("rst_q", q, 0);
      check("rst_owner", owner, 0);
      check("rst_upd", upd, 0);
      step();
      check("rst_gnt_edge", gnt, 0);
      check("rst_q_edge", q, 0);

      // Release: requester 0 has first priority, then full contention
      resetn = 1'b1;
      step();
      check("first_gnt", gnt, 4'b0001);
      check("first_upd", upd, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("cont_q%0d", i), q, exp_cq[i]);
         check($sformatf("cont_owner%0d", i), owner, exp_cown[i]);
         check($sformatf("cont_upd%0d", i), upd, 1);
      end

      // Single requester
      do_reset();
      set_data(2, 8'hA5);
      req = 4'b0100;
      step();
      check("single_gnt", gnt, 4'b0100);
      check("single_upd0", upd, 0);
      check("single_q0", q, 0);
      step();
      check("single_q", q, 8'hA5);
      check("single_owner", owner, 2);
      check("single_upd1", upd, 1);
      req = 4'b0000;
      step();
      check("single_upd_end", upd, 0);
      check("single_q_hold", q, 8'hA5);
      check("single_gnt_idle", gnt, 0);

      // Withdrawn request on requester 1
      do_reset();
      set_data(2, 8'h12);
      req = 4'b0010;
      step();
      check("wd_gnt1", gnt, 4'b0010);
      step();
      check("wd_q_write", q, 8'h11);
      check("wd_owner", owner, 1);
      check("wd_upd1", upd, 1);
      req = 4'b0101;
      step();
      check("wd_q_same", q, 8'h11);
      check("wd_upd0", upd, 0);
      check("wd_next_gnt", gnt, 4'b0100);
      check("wd_owner_same", owner, 1);

      // Reset in the middle of a grant to requester 3
      do_reset();
      req = 4'b1000;
      step();
      check("mr_gnt3", gnt, 4'b1000);
      #2;
      resetn = 1'b0;
      #1;
      check("mr_gnt", gnt, 0);
      check("mr_q", q, 0);
      check("mr_owner", owner, 0);
      check("mr_upd", upd, 0);
      step();
      check("mr_q_edge", q, 0);
      resetn = 1'b1;
      req = 4'hF;
      step();
      check("mr_regnt", gnt, 4'b0001);

      // Two requesters held: lock behaviour when compiled in
      do_reset();
      req = 4'b0011;
      step();
      check("lk_gnt", gnt, 4'b0001);
      for (int i = 0; i < LOCK_N; i++) begin
         step();
         check($sformatf("lk_owner%0d", i), owner, exp_lown[i]);
         check($sformatf("lk_upd%0d", i), upd, 1);
      end
      req = 4'b0000;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
